mem_port_arbiter: RTL

//  Shares one single-port synchronous RAM (e.g. the result matrix memory) between two requesters:

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM-side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    // Arbiter side
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_en, mem_ren, mem_wen, mem_addr, mem_wdata,
        output owner
    );

    // Requester / RAM environment side
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem_en, mem_ren, mem_wen, mem_addr, mem_wdata,
        input  owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port sticky-owner arbiter with burst cap for one single-port sync RAM
module mem_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_CAP = CW'(MAX_BURST);
    localparam logic [CW-1:0] BURST_ONE = CW'(1);

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_nxt;
    logic          rvalid0_q;
    logic          rvalid1_q;

    logic          gnt0;
    logic          gnt1;
    logic          cap_hit;
    logic          owner_gnt;
    logic          other_gnt;
    logic          owner_req;
    logic          other_req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign cap_hit = (burst_cnt == BURST_CAP);

    // Grant decision: a lone requester always wins; under contention the owner
    // keeps the port until it has used up its burst allowance.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.req0 && bus.req1) begin
            if (state == OWN0) begin
                gnt0 = !cap_hit;
                gnt1 = cap_hit;
            end else begin
                gnt1 = !cap_hit;
                gnt0 = cap_hit;
            end
        end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
        end
    end

    always_comb begin
        owner_req = (state == OWN0) ? bus.req0 : bus.req1;
        other_req = (state == OWN0) ? bus.req1 : bus.req0;
        owner_gnt = (state == OWN0) ? gnt0 : gnt1;
        other_gnt = (state == OWN0) ? gnt1 : gnt0;
    end

    // After a handover the new owner's first grant already counts against its
    // burst when the old owner is still waiting, so wait time stays bounded.
    always_comb begin
        state_nxt = state;
        burst_nxt = '0;
        if (owner_gnt) begin
            if (other_req) begin
                burst_nxt = cap_hit ? burst_cnt : burst_cnt + BURST_ONE;
            end
        end else if (other_gnt) begin
            state_nxt = (state == OWN0) ? OWN1 : OWN0;
            burst_nxt = owner_req ? BURST_ONE : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= OWN0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Read-valid pipeline tracks the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 && !bus.we0;
            rvalid1_q <= gnt1 && !bus.we1;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = bus.we0;
            sel_addr  = bus.addr0;
            sel_wdata = bus.wdata0;
        end else if (gnt1) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_en    = gnt0 || gnt1;
    assign bus.mem_wen   = (gnt0 || gnt1) && sel_we;
    assign bus.mem_ren   = (gnt0 || gnt1) && !sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.owner     = (state == OWN1);
endmodule
